// File: rtl/sdram_frame_writer_pkg.sv
// Shared definitions for the SDRAM frame writer and a matching read-side fetcher.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sdram_frame_writer_pkg;

    // Frame capture state encoding, shared with the display-side fetcher
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_VS   = 3'd1,
        ST_LOAD      = 3'd2,
        ST_WAIT_LINE = 3'd3,
        ST_ACTIVE    = 3'd4,
        ST_DONE      = 3'd5
    } fw_state_e;

    // Sticky error flag bit positions
    localparam int ERR_SHORT  = 0;
    localparam int ERR_RESYNC = 1;
    localparam int ERR_W      = 2;

    // Any state other than IDLE counts as busy
    function automatic logic is_busy(input fw_state_e s);
        return (s != ST_IDLE);
    endfunction

endpackage

// File: rtl/sdram_frame_writer_sync_edge_detect.sv
// Registered edge detector: samples the input, keeps the previous sample, flags one edge.
// Latency: edge_o is high for one cycle after the edge that registers the new level.
// Backpressure: none; free-running.
module sync_edge_detect #(
    parameter bit RISE = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic edge_o
);

    logic sig_q;
    logic prev_q;

    // Sample the input and keep one cycle of history
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sig_q  <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            sig_q  <= sig_i;
            prev_q <= sig_q;
        end
    end

    // Select rising or falling transition of the registered sample
    always_comb begin
        edge_o = RISE ? (sig_q & ~prev_q) : (~sig_q & prev_q);
    end

endmodule

// File: rtl/sdram_frame_writer.sv
// Crops a sync-framed pixel stream to H_ACTIVE x V_ACTIVE and feeds SDRAM write port 1.
// Latency: pixel presented before edge n shows on WR1/WR1_DATA after edge n+1.
// Backpressure: none; the controller write FIFO must absorb every line burst.
module sdram_frame_writer
    import sdram_frame_writer_pkg::*;
#(
    parameter int DSIZE       = 16,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int CNT_W       = 12,
    parameter int LOAD_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              EN,
    input  logic              VS_IN,
    input  logic              HS_IN,
    input  logic              PIX_VALID,
    input  logic [DSIZE-1:0]  PIX_DATA,
    output logic [DSIZE-1:0]  WR1_DATA,
    output logic              WR1,
    output logic              WR1_LOAD,
    output logic [CNT_W-1:0]  X_CNT,
    output logic [CNT_W-1:0]  Y_CNT,
    output logic              FRAME_DONE,
    output logic [7:0]        FRAME_CNT,
    output logic [ERR_W-1:0]  ERR,
    output logic              BUSY
);

    // Load-pulse counter wide enough to reach LOAD_CYCLES
    localparam int LC_W = (LOAD_CYCLES < 2) ? 1 : $clog2(LOAD_CYCLES + 1);

    logic              vs_rise;
    logic              hs_fall;

    // Input stage, aligned with the edge detectors' sampling register
    logic              hs_q;
    logic              pix_vld_q;
    logic [DSIZE-1:0]  pix_dat_q;
    logic              en_q;

    fw_state_e         state_q;
    logic [LC_W-1:0]   load_cnt_q;
    logic [CNT_W-1:0]  x_cnt_q;
    logic [CNT_W-1:0]  y_cnt_q;
    logic              wr1_q;
    logic [DSIZE-1:0]  wr1_dat_q;
    logic              wr1_load_q;
    logic              frame_done_q;
    logic [7:0]        frame_cnt_q;
    logic [ERR_W-1:0]  err_q;

    logic              x_room_d;
    logic              pix_take_d;
    logic [CNT_W-1:0]  y_cnt_d;
    logic              en_rise_d;

    sync_edge_detect #(.RISE(1'b1)) u_vs_edge (
        .clk_i  (CLK),
        .rst_i  (RESET),
        .sig_i  (VS_IN),
        .edge_o (vs_rise)
    );

    sync_edge_detect #(.RISE(1'b0)) u_hs_edge (
        .clk_i  (CLK),
        .rst_i  (RESET),
        .sig_i  (HS_IN),
        .edge_o (hs_fall)
    );

    // Register line level, pixel qualifier/data and enable alongside the sync edges
    always_ff @(posedge CLK) begin
        if (RESET) begin
            hs_q      <= 1'b0;
            pix_vld_q <= 1'b0;
            pix_dat_q <= '0;
            en_q      <= 1'b0;
        end else begin
            hs_q      <= HS_IN;
            pix_vld_q <= PIX_VALID;
            pix_dat_q <= PIX_DATA;
            en_q      <= EN;
        end
    end

    // Pixel acceptance, next line count and enable rising edge
    always_comb begin
        x_room_d   = (x_cnt_q < CNT_W'(H_ACTIVE));
        pix_take_d = hs_q & pix_vld_q & x_room_d;
        y_cnt_d    = y_cnt_q + 1'b1;
        en_rise_d  = EN & ~en_q;
    end

    // Frame FSM with crop counters, write strobes and sticky error flags
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            load_cnt_q   <= '0;
            x_cnt_q      <= '0;
            y_cnt_q      <= '0;
            wr1_q        <= 1'b0;
            wr1_dat_q    <= '0;
            wr1_load_q   <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
            err_q        <= '0;
        end else begin
            // Strobes are single-cycle unless a state re-asserts them
            wr1_q        <= 1'b0;
            wr1_load_q   <= 1'b0;
            frame_done_q <= 1'b0;

            // Re-enabling capture clears the sticky flags; a new error this cycle still wins
            if (en_rise_d) begin
                err_q <= '0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (EN) begin
                        state_q <= ST_WAIT_VS;
                    end
                end

                ST_WAIT_VS: begin
                    if (!EN) begin
                        state_q <= ST_IDLE;
                    end else if (vs_rise) begin
                        state_q    <= ST_LOAD;
                        wr1_load_q <= 1'b1;
                        load_cnt_q <= LC_W'(1);
                        x_cnt_q    <= '0;
                        y_cnt_q    <= '0;
                    end
                end

                // Hold the address reload for LOAD_CYCLES clocks; pixels are dropped here
                ST_LOAD: begin
                    if (load_cnt_q == LC_W'(LOAD_CYCLES)) begin
                        state_q <= ST_WAIT_LINE;
                    end else begin
                        wr1_load_q <= 1'b1;
                        load_cnt_q <= load_cnt_q + 1'b1;
                    end
                end

                ST_WAIT_LINE: begin
                    if (vs_rise) begin
                        // Frame sync arrived mid-frame: restart without reporting completion
                        err_q[ERR_RESYNC] <= 1'b1;
                        state_q           <= ST_LOAD;
                        wr1_load_q        <= 1'b1;
                        load_cnt_q        <= LC_W'(1);
                        x_cnt_q           <= '0;
                        y_cnt_q           <= '0;
                    end else if (hs_q) begin
                        state_q <= ST_ACTIVE;
                        if (pix_take_d) begin
                            wr1_q     <= 1'b1;
                            wr1_dat_q <= pix_dat_q;
                            x_cnt_q   <= x_cnt_q + 1'b1;
                        end
                    end
                end

                ST_ACTIVE: begin
                    if (vs_rise) begin
                        err_q[ERR_RESYNC] <= 1'b1;
                        state_q           <= ST_LOAD;
                        wr1_load_q        <= 1'b1;
                        load_cnt_q        <= LC_W'(1);
                        x_cnt_q           <= '0;
                        y_cnt_q           <= '0;
                    end else if (hs_fall) begin
                        // A short line is flagged but still occupies a line slot
                        if (!x_room_d) begin
                            state_q <= state_q;
                        end else begin
                            err_q[ERR_SHORT] <= 1'b1;
                        end
                        x_cnt_q <= '0;
                        y_cnt_q <= y_cnt_d;
                        if (y_cnt_d == CNT_W'(V_ACTIVE)) begin
                            state_q      <= ST_DONE;
                            frame_done_q <= 1'b1;
                            frame_cnt_q  <= frame_cnt_q + 1'b1;
                        end else begin
                            state_q <= ST_WAIT_LINE;
                        end
                    end else if (pix_take_d) begin
                        wr1_q     <= 1'b1;
                        wr1_dat_q <= pix_dat_q;
                        x_cnt_q   <= x_cnt_q + 1'b1;
                    end
                end

                // A dropped enable takes effect only once the frame has finished
                ST_DONE: begin
                    state_q <= EN ? ST_WAIT_VS : ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign WR1_DATA   = wr1_dat_q;
    assign WR1        = wr1_q;
    assign WR1_LOAD   = wr1_load_q;
    assign X_CNT      = x_cnt_q;
    assign Y_CNT      = y_cnt_q;
    assign FRAME_DONE = frame_done_q;
    assign FRAME_CNT  = frame_cnt_q;
    assign ERR        = err_q;
    assign BUSY       = is_busy(state_q);

endmodule

// File: tb/tb_sdram_frame_writer.sv
// Directed bench for sdram_frame_writer with a 4x2 crop window.
// Latency: n/a.
// Backpressure: n/a.
module tb_sdram_frame_writer;

    localparam int DSIZE = 16;
    localparam int CNT_W = 12;

    logic              CLK;
    logic              RESET;
    logic              EN;
    logic              VS_IN;
    logic              HS_IN;
    logic              PIX_VALID;
    logic [DSIZE-1:0]  PIX_DATA;
    logic [DSIZE-1:0]  WR1_DATA;
    logic              WR1;
    logic              WR1_LOAD;
    logic [CNT_W-1:0]  X_CNT;
    logic [CNT_W-1:0]  Y_CNT;
    logic              FRAME_DONE;
    logic [7:0]        FRAME_CNT;
    logic [1:0]        ERR;
    logic              BUSY;

    int pass_cnt;
    int total_cnt;

    // Observed activity, collected mid-cycle
    logic [DSIZE-1:0] wr_log[$];
    int load_cyc;
    int done_cnt;
    int overlap_cnt;

    sdram_frame_writer #(
        .DSIZE(DSIZE), .H_ACTIVE(4), .V_ACTIVE(2), .CNT_W(CNT_W), .LOAD_CYCLES(2)
    ) dut (
        .CLK(CLK), .RESET(RESET), .EN(EN), .VS_IN(VS_IN), .HS_IN(HS_IN),
        .PIX_VALID(PIX_VALID), .PIX_DATA(PIX_DATA), .WR1_DATA(WR1_DATA), .WR1(WR1),
        .WR1_LOAD(WR1_LOAD), .X_CNT(X_CNT), .Y_CNT(Y_CNT), .FRAME_DONE(FRAME_DONE),
        .FRAME_CNT(FRAME_CNT), .ERR(ERR), .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (WR1) wr_log.push_back(WR1_DATA);
        if (WR1_LOAD) load_cyc++;
        if (FRAME_DONE) done_cnt++;
        if (WR1 && WR1_LOAD) overlap_cnt++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        VS_IN = 0; HS_IN = 0; PIX_VALID = 0; PIX_DATA = '0; EN = 1;
        RESET = 1;
        tick(); tick();
        RESET = 0;
        tick(); tick();
    endtask

    task automatic vs_pulse();
        VS_IN = 1;
        tick(); tick();
        VS_IN = 0;
        repeat (5) tick();
    endtask

    task automatic send_line(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            HS_IN = 1; PIX_VALID = 1; PIX_DATA = DSIZE'(base + i);
            tick();
        end
        HS_IN = 0; PIX_VALID = 0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        VS_IN = 0; HS_IN = 0; PIX_VALID = 0; PIX_DATA = '0; EN = 1;
        RESET = 1;
        tick(); tick(); tick();
        total_cnt++; if (WR1 !== 1'b0) $display("FAIL reset_wr1: got %0h want 0", WR1); else pass_cnt++;
        total_cnt++; if (WR1_DATA !== 16'h0) $display("FAIL reset_wr1_data: got %0h want 0", WR1_DATA); else pass_cnt++;
        total_cnt++; if (WR1_LOAD !== 1'b0) $display("FAIL reset_wr1_load: got %0h want 0", WR1_LOAD); else pass_cnt++;
        total_cnt++; if (X_CNT !== 12'd0) $display("FAIL reset_x_cnt: got %0d want 0", X_CNT); else pass_cnt++;
        total_cnt++; if (Y_CNT !== 12'd0) $display("FAIL reset_y_cnt: got %0d want 0", Y_CNT); else pass_cnt++;
        total_cnt++; if (FRAME_DONE !== 1'b0) $display("FAIL reset_frame_done: got %0h want 0", FRAME_DONE); else pass_cnt++;
        total_cnt++; if (FRAME_CNT !== 8'd0) $display("FAIL reset_frame_cnt: got %0d want 0", FRAME_CNT); else pass_cnt++;
        total_cnt++; if (ERR !== 2'b00) $display("FAIL reset_err: got %0h want 0", ERR); else pass_cnt++;
        total_cnt++; if (BUSY !== 1'b0) $display("FAIL reset_busy: got %0h want 0", BUSY); else pass_cnt++;
        RESET = 0;
        tick(); tick();
        total_cnt++; if (BUSY !== 1'b1) $display("FAIL reset_to_wait_vs_busy: got %0h want 1", BUSY); else pass_cnt++;
    endtask

    task automatic test_clean_frame();
        int b_wr;
        int b_load;
        int b_done;
        do_reset();
        b_wr = wr_log.size(); b_load = load_cyc; b_done = done_cnt;
        // VS rises before edge n: reload visible after n+1 and n+2 only
        VS_IN = 1;
        tick();
        total_cnt++; if (WR1_LOAD !== 1'b0) $display("FAIL load_lat_n: got %0h want 0", WR1_LOAD); else pass_cnt++;
        tick();
        total_cnt++; if (WR1_LOAD !== 1'b1) $display("FAIL load_lat_n1: got %0h want 1", WR1_LOAD); else pass_cnt++;
        tick();
        total_cnt++; if (WR1_LOAD !== 1'b1) $display("FAIL load_lat_n2: got %0h want 1", WR1_LOAD); else pass_cnt++;
        tick();
        total_cnt++; if (WR1_LOAD !== 1'b0) $display("FAIL load_lat_n3: got %0h want 0", WR1_LOAD); else pass_cnt++;
        VS_IN = 0;
        tick(); tick();
        // First pixel before edge m appears after edge m+1
        HS_IN = 1; PIX_VALID = 1; PIX_DATA = 16'h0001;
        tick();
        total_cnt++; if (WR1 !== 1'b0) $display("FAIL pix_lat_early: got %0h want 0", WR1); else pass_cnt++;
        PIX_DATA = 16'h0002;
        tick();
        total_cnt++; if (WR1 !== 1'b1 || WR1_DATA !== 16'h0001) $display("FAIL pix_lat: got wr1=%0h data=%0h want 1/0001", WR1, WR1_DATA); else pass_cnt++;
        PIX_DATA = 16'h0003; tick();
        PIX_DATA = 16'h0004; tick();
        HS_IN = 0; PIX_VALID = 0;
        repeat (4) tick();
        total_cnt++; if (WR1 !== 1'b0 || WR1_DATA !== 16'h0004) $display("FAIL data_hold: got wr1=%0h data=%0h want 0/0004", WR1, WR1_DATA); else pass_cnt++;
        total_cnt++; if (Y_CNT !== 12'd1) $display("FAIL line1_y_cnt: got %0d want 1", Y_CNT); else pass_cnt++;
        send_line(4, 5);
        total_cnt++; if (wr_log.size() - b_wr !== 8) $display("FAIL frame_wr_count: got %0d want 8", wr_log.size() - b_wr); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            total_cnt++;
            if (wr_log[b_wr + i] !== DSIZE'(i + 1)) $display("FAIL frame_data[%0d]: got %0h want %0h", i, wr_log[b_wr + i], i + 1);
            else pass_cnt++;
        end
        total_cnt++; if (load_cyc - b_load !== 2) $display("FAIL frame_load_cycles: got %0d want 2", load_cyc - b_load); else pass_cnt++;
        total_cnt++; if (done_cnt - b_done !== 1) $display("FAIL frame_done_count: got %0d want 1", done_cnt - b_done); else pass_cnt++;
        total_cnt++; if (FRAME_CNT !== 8'd1) $display("FAIL frame_cnt: got %0d want 1", FRAME_CNT); else pass_cnt++;
        total_cnt++; if (ERR !== 2'b00) $display("FAIL frame_err: got %0h want 0", ERR); else pass_cnt++;
        total_cnt++; if (Y_CNT !== 12'd2) $display("FAIL frame_y_cnt: got %0d want 2", Y_CNT); else pass_cnt++;
        total_cnt++; if (BUSY !== 1'b1) $display("FAIL frame_busy_wait_vs: got %0h want 1", BUSY); else pass_cnt++;
    endtask

    task automatic test_long_line();
        int b_wr;
        do_reset();
        vs_pulse();
        b_wr = wr_log.size();
        for (int i = 0; i < 6; i++) begin
            HS_IN = 1; PIX_VALID = 1; PIX_DATA = DSIZE'(16'hA0 + i);
            tick();
        end
        PIX_VALID = 0;
        tick(); tick();
        total_cnt++; if (X_CNT !== 12'd4) $display("FAIL long_x_sat: got %0d want 4", X_CNT); else pass_cnt++;
        HS_IN = 0;
        repeat (4) tick();
        total_cnt++; if (wr_log.size() - b_wr !== 4) $display("FAIL long_wr_count: got %0d want 4", wr_log.size() - b_wr); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (wr_log[b_wr + i] !== DSIZE'(16'hA0 + i)) $display("FAIL long_data[%0d]: got %0h want %0h", i, wr_log[b_wr + i], 16'hA0 + i);
            else pass_cnt++;
        end
        total_cnt++; if (ERR !== 2'b00) $display("FAIL long_err: got %0h want 0", ERR); else pass_cnt++;
        total_cnt++; if (Y_CNT !== 12'd1) $display("FAIL long_y_cnt: got %0d want 1", Y_CNT); else pass_cnt++;
    endtask

    task automatic test_short_line();
        int b_wr;
        int b_done;
        do_reset();
        vs_pulse();
        b_wr = wr_log.size(); b_done = done_cnt;
        send_line(3, 16'hB0);
        total_cnt++; if (ERR !== 2'b01) $display("FAIL short_err: got %0h want 1", ERR); else pass_cnt++;
        total_cnt++; if (Y_CNT !== 12'd1) $display("FAIL short_y_cnt: got %0d want 1", Y_CNT); else pass_cnt++;
        total_cnt++; if (X_CNT !== 12'd0) $display("FAIL short_x_clr: got %0d want 0", X_CNT); else pass_cnt++;
        send_line(4, 16'hC0);
        total_cnt++; if (wr_log.size() - b_wr !== 7) $display("FAIL short_wr_count: got %0d want 7", wr_log.size() - b_wr); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (wr_log[b_wr + 3 + i] !== DSIZE'(16'hC0 + i)) $display("FAIL short_next_data[%0d]: got %0h want %0h", i, wr_log[b_wr + 3 + i], 16'hC0 + i);
            else pass_cnt++;
        end
        total_cnt++; if (done_cnt - b_done !== 1) $display("FAIL short_done: got %0d want 1", done_cnt - b_done); else pass_cnt++;
    endtask

    task automatic test_resync();
        int b_load;
        int b_done;
        do_reset();
        vs_pulse();
        send_line(4, 16'h10);
        b_load = load_cyc; b_done = done_cnt;
        vs_pulse();
        total_cnt++; if (ERR !== 2'b10) $display("FAIL resync_err: got %0h want 2", ERR); else pass_cnt++;
        total_cnt++; if (load_cyc - b_load !== 2) $display("FAIL resync_load: got %0d want 2", load_cyc - b_load); else pass_cnt++;
        total_cnt++; if (done_cnt - b_done !== 0) $display("FAIL resync_no_done: got %0d want 0", done_cnt - b_done); else pass_cnt++;
        total_cnt++; if (Y_CNT !== 12'd0) $display("FAIL resync_y_clr: got %0d want 0", Y_CNT); else pass_cnt++;
        send_line(4, 16'h20);
        send_line(4, 16'h24);
        total_cnt++; if (done_cnt - b_done !== 1) $display("FAIL resync_next_done: got %0d want 1", done_cnt - b_done); else pass_cnt++;
        total_cnt++; if (FRAME_CNT !== 8'd1) $display("FAIL resync_frame_cnt: got %0d want 1", FRAME_CNT); else pass_cnt++;
    endtask

    task automatic test_en_drop();
        int b_load;
        int b_done;
        do_reset();
        vs_pulse();
        b_done = done_cnt;
        send_line(4, 16'h30);
        EN = 0;
        send_line(4, 16'h34);
        total_cnt++; if (done_cnt - b_done !== 1) $display("FAIL endrop_done: got %0d want 1", done_cnt - b_done); else pass_cnt++;
        total_cnt++; if (FRAME_CNT !== 8'd1) $display("FAIL endrop_frame_cnt: got %0d want 1", FRAME_CNT); else pass_cnt++;
        total_cnt++; if (BUSY !== 1'b0) $display("FAIL endrop_idle: got %0h want 0", BUSY); else pass_cnt++;
        b_load = load_cyc;
        vs_pulse();
        total_cnt++; if (load_cyc - b_load !== 0) $display("FAIL endrop_no_load: got %0d want 0", load_cyc - b_load); else pass_cnt++;
        total_cnt++; if (BUSY !== 1'b0) $display("FAIL endrop_stay_idle: got %0h want 0", BUSY); else pass_cnt++;
        EN = 1;
    endtask

    task automatic test_reset_active();
        do_reset();
        vs_pulse();
        HS_IN = 1; PIX_VALID = 1; PIX_DATA = 16'h0055;
        tick();
        PIX_DATA = 16'h0056;
        tick(); tick();
        total_cnt++; if (WR1 !== 1'b1) $display("FAIL rstact_flowing: got %0h want 1", WR1); else pass_cnt++;
        RESET = 1;
        tick();
        total_cnt++; if (WR1 !== 1'b0) $display("FAIL rstact_wr1: got %0h want 0", WR1); else pass_cnt++;
        total_cnt++; if (WR1_DATA !== 16'h0) $display("FAIL rstact_data: got %0h want 0", WR1_DATA); else pass_cnt++;
        total_cnt++; if (WR1_LOAD !== 1'b0) $display("FAIL rstact_load: got %0h want 0", WR1_LOAD); else pass_cnt++;
        total_cnt++; if (X_CNT !== 12'd0) $display("FAIL rstact_x: got %0d want 0", X_CNT); else pass_cnt++;
        total_cnt++; if (Y_CNT !== 12'd0) $display("FAIL rstact_y: got %0d want 0", Y_CNT); else pass_cnt++;
        total_cnt++; if (FRAME_DONE !== 1'b0) $display("FAIL rstact_done: got %0h want 0", FRAME_DONE); else pass_cnt++;
        total_cnt++; if (FRAME_CNT !== 8'd0) $display("FAIL rstact_frame_cnt: got %0d want 0", FRAME_CNT); else pass_cnt++;
        total_cnt++; if (ERR !== 2'b00) $display("FAIL rstact_err: got %0h want 0", ERR); else pass_cnt++;
        total_cnt++; if (BUSY !== 1'b0) $display("FAIL rstact_busy: got %0h want 0", BUSY); else pass_cnt++;
        tick();
        total_cnt++; if (WR1 !== 1'b0) $display("FAIL rstact_wr1_held: got %0h want 0", WR1); else pass_cnt++;
        RESET = 0; HS_IN = 0; PIX_VALID = 0;
        tick();
    endtask

    initial begin
        pass_cnt = 0; total_cnt = 0;
        load_cyc = 0; done_cnt = 0; overlap_cnt = 0;
        test_reset();
        test_clean_frame();
        test_long_line();
        test_short_line();
        test_resync();
        test_en_drop();
        test_reset_active();
        total_cnt++; if (overlap_cnt !== 0) $display("FAIL wr1_load_overlap: got %0d want 0", overlap_cnt); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sdram_frame_writer.md
# sdram_frame_writer

Capture-side feeder for the SDRAM controller's write port 1. Takes a raw sync-framed pixel stream (frame sync, line valid, pixel valid), crops it to a fixed H_ACTIVE × V_ACTIVE window, and drives WR1_DATA/WR1 into the write FIFO. At each frame start it pulses WR1_LOAD, which rewinds the controller's write address and clears the FIFO. Runs entirely in the write-FIFO clock domain (WR1_CLK).

## Interface
- DSIZE, 16, pixel/data word width; equals the controller data width
- H_ACTIVE, 640, pixels written per line
- V_ACTIVE, 480, lines written per frame
- CNT_W, 12, width of X/Y counters; must hold H_ACTIVE and V_ACTIVE
- LOAD_CYCLES, 2, WR1_LOAD pulse length in clocks, ≥1
- CLK  in  1  capture clock; the same net drives controller WR1_CLK
- RESET  in  1  synchronous, active-high reset
- EN  in  1  capture enable, level
- VS_IN  in  1  frame sync, active high; a rising edge starts a frame
- HS_IN  in  1  line valid, active high
- PIX_VALID  in  1  pixel qualifier
- PIX_DATA  in  DSIZE  pixel word
- WR1_DATA  out  DSIZE  to controller WR1_DATA
- WR1  out  1  to controller WR1 (FIFO write request)
- WR1_LOAD  out  1  to controller WR1_LOAD (address reload and FIFO clear)
- X_CNT  out  CNT_W  pixels accepted in the current line
- Y_CNT  out  CNT_W  completed lines in the current frame
- FRAME_DONE  out  1  one-clock pulse when line V_ACTIVE completes
- FRAME_CNT  out  8  completed-frame counter, wraps 255→0
- ERR  out  2  sticky flags: [0] short line, [1] frame restarted mid-frame; cleared by RESET or by a rising edge of EN
- BUSY  out  1  high in any state except IDLE

## Operation
- Registered edge detectors on VS_IN and HS_IN.
  - vs_rise = VS_IN & ~vs_d
  - hs_fall = ~HS_IN & hs_d
- States: IDLE, WAIT_VS, LOAD, WAIT_LINE, ACTIVE, DONE.
- IDLE: if EN=1 → WAIT_VS.
- WAIT_VS: on vs_rise → LOAD.
- LOAD: WR1_LOAD=1 for LOAD_CYCLES clocks; clear X_CNT and Y_CNT; → WAIT_LINE. Pixels arriving in LOAD are dropped.
- WAIT_LINE: when HS_IN=1 → ACTIVE. That same cycle's pixel is accepted if PIX_VALID=1.
- ACTIVE:
  - A pixel is accepted when HS_IN & PIX_VALID & (X_CNT < H_ACTIVE); accepting increments X_CNT.
  - Pixels beyond H_ACTIVE are dropped silently.
  - On hs_fall: if X_CNT < H_ACTIVE, set ERR[0]; the line still counts. Then Y_CNT+1 and X_CNT cleared. If new Y_CNT == V_ACTIVE → DONE, else → WAIT_LINE.
- DONE: FRAME_DONE=1 for one clock; FRAME_CNT+1. → WAIT_VS if EN=1, else IDLE.
- vs_rise in WAIT_LINE or ACTIVE: set ERR[1] and go directly to LOAD (resync). FRAME_DONE is not issued for the aborted frame.
- EN falling mid-frame: the current frame completes normally; DONE then returns to IDLE. EN falling in WAIT_VS: → IDLE.
- No pixels are accepted in IDLE, WAIT_VS, LOAD or DONE.
- Counter rules:
  - X_CNT saturates at H_ACTIVE.
  - Y_CNT never exceeds V_ACTIVE.
  - FRAME_CNT is modulo 256.

## Timing
- Reset values: state IDLE; WR1=0; WR1_DATA=0; WR1_LOAD=0; X_CNT=0; Y_CNT=0; FRAME_DONE=0; FRAME_CNT=0; ERR=0; BUSY=0; edge registers 0.
- Pixel latency: an accepted pixel at edge n appears as WR1=1 with WR1_DATA=PIX_DATA on the outputs after edge n+1. WR1_DATA holds its value when WR1=0.
- WR1_LOAD: VS_IN rises before edge n → vs_rise seen at edge n+1 → WR1_LOAD high for cycles n+2 … n+1+LOAD_CYCLES.
- WR1 and WR1_LOAD are never high in the same cycle.
- FRAME_DONE: high the cycle after the edge that registers the final hs_fall.
- There is no backpressure. The controller's write FIFO must absorb a line burst, so the minimum horizontal blanking is set by SDRAM bandwidth and is out of scope here.

## Structure
- Shared package holds the state encoding enum (IDLE…DONE) and the ERR bit index constants (ERR_SHORT=0, ERR_RESYNC=1), for reuse by a matching read-side display fetcher.
- Natural sub-module: sync_edge_detect (registered rise/fall detector), instantiated once for VS_IN and once for HS_IN.
- Everything else sits in one FSM plus counter process.

## Test plan
- Use H_ACTIVE=4, V_ACTIVE=2, LOAD_CYCLES=2 unless noted.
- Reset with EN=1, then a clean frame of 2 lines × 4 pixels, data 0x0001–0x0008 → WR1_LOAD high exactly 2 cycles; 8 WR1 pulses carrying 0x0001…0x0008 in order; one FRAME_DONE; FRAME_CNT=1; ERR=0.
- Line of 6 pixels (0xA0–0xA5) → only 0xA0–0xA3 written; X_CNT stays 4; ERR=0.
- Line of 3 pixels → ERR[0]=1; Y_CNT increments; the next line is still written.
- VS_IN rises after line 1 of a frame → ERR[1]=1; WR1_LOAD pulses again; no FRAME_DONE for that frame; the next full frame completes with FRAME_CNT=1.
- EN dropped mid-frame → the frame completes, FRAME_DONE fires, state returns to IDLE; a following VS_IN rise produces no WR1_LOAD.
- Assert RESET during ACTIVE with pixels flowing → next cycle all outputs at reset values; WR1=0 even with PIX_VALID=1.
